// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: defaults,
// frame size and FSM state encoding.
package fifo_uart_pkg;

    localparam int DEF_CLKS_PER_BIT = 32;
    localparam int DEF_DATA_W       = 8;
    localparam int FRAME_BITS       = DEF_DATA_W + 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit baud counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last (bit_end) and second-to-last (pre_end) cycle of each bit.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 32,
    localparam int CNT_W = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_end,
    output logic pre_end
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] baud_cnt;

    assign bit_end = enable && (baud_cnt == LAST);
    assign pre_end = enable && (baud_cnt == PRE);

    // The count never overflows: it is cleared explicitly at the bit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else if (clear || bit_end) begin
            baud_cnt <= '0;
        end else if (enable) begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops bytes from a FIFO with a one-cycle read
// strobe and serialises them LSB first on tx.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_W       = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              tx_busy,
    output logic              frame_done,
    output tx_state_e         dbg_state
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_e         state;
    logic [DATA_W-1:0] shift_reg;
    logic [IDX_W-1:0]  bit_idx;
    logic              timer_clear;
    logic              timer_en;
    logic              bit_end;
    logic              pre_end;

    assign timer_en    = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
    assign timer_clear = (state == ST_LATCH);
    assign dbg_state   = state;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_en),
        .bit_end (bit_end),
        .pre_end (pre_end)
    );

    // fifo_empty is only looked at in IDLE and on the final STOP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            fifo_rd_en <= 1'b0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
            shift_reg  <= '0;
            bit_idx    <= '0;
        end else begin
            fifo_rd_en <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        state      <= ST_FETCH;
                        fifo_rd_en <= 1'b1;
                        tx_busy    <= 1'b1;
                    end
                end
                ST_FETCH: state <= ST_LATCH;
                ST_LATCH: begin
                    shift_reg <= fifo_rd_data;
                    bit_idx   <= '0;
                    tx        <= 1'b0;
                    state     <= ST_START;
                end
                ST_START: begin
                    if (bit_end) begin
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_IDX) begin
                            tx    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_idx   <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    // Registered one cycle early so the pulse lands on the last stop cycle.
                    frame_done <= pre_end;
                    if (bit_end) begin
                        if (!fifo_empty) begin
                            state      <= ST_FETCH;
                            fifo_rd_en <= 1'b1;
                        end else begin
                            state   <= ST_IDLE;
                            tx_busy <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO models feed two instances (default rate and
// CLKS_PER_BIT=2); a receiver monitor checks each frame against exp_q.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       fifo_empty = 1'b1, fifo_empty2 = 1'b1;
    logic [7:0] rd_data = 8'h00, rd_data2 = 8'h00;
    logic       rd_en, rd_en2, tx, tx2, busy, busy2, fd, fd2;
    fifo_uart_pkg::tx_state_e st, st2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] fifo_q2[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_q2[$];
    int rd_t[$];
    int last_rd[2] = '{0, 0};
    int frames[2] = '{0, 0};
    int rd_cnt2 = 0;
    logic rd_prev = 1'b0, rd_prev2 = 1'b0;
    logic ovr_en = 1'b0, ovr_val = 1'b0;

    fifo_uart_tx dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_data(rd_data),
        .fifo_rd_en(rd_en), .tx(tx), .tx_busy(busy), .frame_done(fd), .dbg_state(st)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(2), .DATA_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty2), .fifo_rd_data(rd_data2),
        .fifo_rd_en(rd_en2), .tx(tx2), .tx_busy(busy2), .frame_done(fd2), .dbg_state(st2)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en && fifo_q.size() != 0) rd_data <= fifo_q.pop_front();
        if (rd_en2 && fifo_q2.size() != 0) rd_data2 <= fifo_q2.pop_front();
    end

    always @(negedge clk) begin
        fifo_empty  = ovr_en ? ovr_val : (fifo_q.size() == 0);
        fifo_empty2 = (fifo_q2.size() == 0);
        if (rd_en) begin
            checks++;
            if (rd_prev || fifo_q.size() == 0) begin
                errors++;
                $display("FAIL rd_pulse: cycle %0d wide=%b fifo_depth=%0d required single pulse on non-empty fifo",
                         cyc, rd_prev, fifo_q.size());
            end
            rd_t.push_back(cyc);
            last_rd[0] = cyc;
        end
        if (rd_en2) begin
            checks++;
            if (rd_prev2 || fifo_q2.size() == 0) begin
                errors++;
                $display("FAIL rd_pulse2: cycle %0d wide=%b fifo_depth=%0d required single pulse on non-empty fifo",
                         cyc, rd_prev2, fifo_q2.size());
            end
            rd_cnt2++;
            last_rd[1] = cyc;
        end
        rd_prev  = rd_en;
        rd_prev2 = rd_en2;
    end

    function automatic logic mon_tx(input int w);
        return (w == 0) ? tx : tx2;
    endfunction

    function automatic logic mon_fd(input int w);
        return (w == 0) ? fd : fd2;
    endfunction

    function automatic logic mon_busy(input int w);
        return (w == 0) ? busy : busy2;
    endfunction

    function automatic logic [8:0] exp_pop(input int w);
        if (w == 0) begin
            if (exp_q.size() == 0) return 9'h000;
            return {1'b1, exp_q.pop_front()};
        end
        if (exp_q2.size() == 0) return 9'h000;
        return {1'b1, exp_q2.pop_front()};
    endfunction

    // Receiver: on a falling tx, pop the expected byte and compare every cycle.
    task automatic frame_monitor(input int w, input int clks);
        logic [8:0] e;
        logic [9:0] fr;
        logic       lvl;
        int         bad_at;
        logic       aborted;
        logic       got_tx, got_fd, got_busy;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (mon_fd(w)) begin
                checks++;
                errors++;
                $display("FAIL stray_frame_done[%0d]: frame_done=1 outside a frame at cycle %0d, required 0", w, cyc);
            end
            if (mon_tx(w) == 1'b0) begin
                checks++;
                if (cyc - last_rd[w] != 2) begin
                    errors++;
                    $display("FAIL start_latency[%0d]: %0d cycles after rd strobe, required 2", w, cyc - last_rd[w]);
                end
                e = exp_pop(w);
                if (!e[8]) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame[%0d]: frame at cycle %0d with no byte expected", w, cyc);
                end
                fr = {1'b1, e[7:0], 1'b0};
                bad_at = -1;
                aborted = 1'b0;
                got_tx = 1'b0; got_fd = 1'b0; got_busy = 1'b0;
                for (int c = 1; c <= 10 * clks; c++) begin
                    if (c > 1) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    lvl = fr[(c - 1) / clks];
                    if (bad_at < 0 && (mon_tx(w) !== lvl || mon_fd(w) !== (c == 10 * clks) || mon_busy(w) !== 1'b1)) begin
                        bad_at = c;
                        got_tx = mon_tx(w); got_fd = mon_fd(w); got_busy = mon_busy(w);
                    end
                end
                if (!aborted) begin
                    checks++;
                    if (bad_at >= 0) begin
                        errors++;
                        $display("FAIL frame[%0d] byte %02h: frame cycle %0d got tx=%b frame_done=%b busy=%b, required tx=%b frame_done=%b busy=1",
                                 w, e[7:0], bad_at, got_tx, got_fd, got_busy, fr[(bad_at - 1) / clks], (bad_at == 10 * clks));
                    end
                    frames[w]++;
                end
            end
        end
    endtask

    initial frame_monitor(0, 32);
    initial frame_monitor(1, 2);

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic push1(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_frames(input int w, input int n, input int budget, input string name);
        int k = 0;
        while (frames[w] < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, frames[w], n);
    endtask

    task automatic wait_rd(input int n0, input string name);
        int k = 0;
        while (rd_t.size() <= n0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, (rd_t.size() > n0) ? 1 : 0, 1);
    endtask

    initial begin
        int n0;
        int bad;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", int'(tx), 1);
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(fd), 0);
        check("rst_state", int'(st), 0);
        check("rst_tx2", int'(tx2), 1);
        rst_n = 1'b1;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || rd_en !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("idle_hold_bad_cycles", bad, 0);

        // Single byte 0xA5
        n0 = rd_t.size();
        push1(8'hA5);
        wait_frames(0, 1, 1000, "a5_frame");
        repeat (3) @(negedge clk);
        check("a5_rd_pulses", rd_t.size() - n0, 1);
        check("a5_busy_after", int'(busy), 0);
        check("a5_tx_after", int'(tx), 1);

        // Back-to-back 0x00, 0xFF, 0x55
        n0 = rd_t.size();
        push1(8'h00); push1(8'hFF); push1(8'h55);
        wait_frames(0, 4, 2000, "b2b_frames");
        repeat (3) @(negedge clk);
        check("b2b_rd_pulses", rd_t.size() - n0, 3);
        if (rd_t.size() >= n0 + 3) begin
            check("b2b_period_1", rd_t[n0 + 1] - rd_t[n0], 322);
            check("b2b_period_2", rd_t[n0 + 2] - rd_t[n0 + 1], 322);
        end

        // fifo_empty toggled mid-frame must be ignored
        n0 = rd_t.size();
        push1(8'h3C); push1(8'hC3);
        wait_rd(n0, "toggle_first_rd");
        ovr_en = 1'b1;
        repeat (300) begin
            ovr_val = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        ovr_en = 1'b0;
        wait_frames(0, 6, 1000, "toggle_frames");
        repeat (3) @(negedge clk);
        check("toggle_rd_pulses", rd_t.size() - n0, 2);
        if (rd_t.size() >= n0 + 2) check("toggle_period", rd_t[n0 + 1] - rd_t[n0], 322);

        // Reset during data bit 3 of 0x37; 0x5A must follow cleanly
        n0 = rd_t.size();
        push1(8'h37); push1(8'h5A);
        wait_rd(n0, "rst_mid_first_rd");
        repeat (2 + 4 * 32 + 10) @(negedge clk);
        check("rst_mid_tx_before", int'(tx), 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_tx", int'(tx), 1);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_rd_en", int'(rd_en), 0);
        check("rst_mid_state", int'(st), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_frames(0, 7, 1000, "rst_mid_next_frame");
        repeat (3) @(negedge clk);
        check("rst_mid_rd_pulses", rd_t.size() - n0, 2);

        // CLKS_PER_BIT=2, byte 0x81
        fifo_q2.push_back(8'h81);
        exp_q2.push_back(8'h81);
        wait_frames(1, 1, 200, "fast_frame");
        repeat (3) @(negedge clk);
        check("fast_rd_pulses", rd_cnt2, 1);
        check("fast_busy_after", int'(busy2), 0);

        check("exp_q_left", exp_q.size(), 0);
        check("exp_q2_left", exp_q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: bench did not complete by %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
